// File: rtl/alu_dispatch.sv
// ---------------------------------------------------------------------------
// alu_dispatch
//
// Queues ALU requests in a small FIFO and issues them, one at a time, to an
// external combinational ALU. The ALU result is captured into response
// registers and held until the consumer accepts it. Responses come back in
// request order. Illegal opcodes bypass the ALU and return an error
// response.
//
// Parameters
//   DEPTH  request FIFO depth in entries (power of two, 2..16)
//   CNTW   width of the completed-response counter
//
// Ports
//   clk_i         clock, all state on rising edge
//   rst_i         asynchronous active-high reset
//   req_valid_i   request valid
//   req_ready_o   FIFO has space (not full)
//   req_op_i      ALU operation code
//   req_a_i       operand A
//   req_b_i       operand B
//   req_tag_i     requester tag, echoed on the response
//   alu_src1_o    operand A to the ALU
//   alu_src2_o    operand B to the ALU
//   alu_ctrl_o    control code to the ALU
//   alu_result_i  combinational ALU result
//   alu_zero_i    ALU zero flag
//   rsp_valid_o   response valid
//   rsp_ready_i   consumer accepts the response
//   rsp_result_o  captured result
//   rsp_zero_o    captured zero flag
//   rsp_err_o     illegal opcode flag
//   rsp_tag_o     echoed request tag
//   done_cnt_o    number of completed response handshakes (wraps)
// ---------------------------------------------------------------------------
module alu_dispatch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      req_op_i,
  input  logic [31:0]     req_a_i,
  input  logic [31:0]     req_b_i,
  input  logic [3:0]      req_tag_i,
  output logic [31:0]     alu_src1_o,
  output logic [31:0]     alu_src2_o,
  output logic [3:0]      alu_ctrl_o,
  input  logic [31:0]     alu_result_i,
  input  logic            alu_zero_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_result_o,
  output logic            rsp_zero_o,
  output logic            rsp_err_o,
  output logic [3:0]      rsp_tag_o,
  output logic [CNTW-1:0] done_cnt_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------
  req_t          fifo_mem_q [0:DEPTH-1];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;
  logic   rsp_hs;
  req_t   head;
  req_t   wr_entry;
  state_t state_q;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign req_ready_o = ~fifo_full;

  // A full FIFO refuses the push even when a pop happens on the same edge.
  assign push = req_valid_i & ~fifo_full;

  // Response handshake: only meaningful while a response is held.
  assign rsp_hs = (state_q == S_HOLD) & rsp_ready_i;

  // The head is consumed when the FSM can start a new operation: from IDLE,
  // or straight out of HOLD on the handshake edge (back-to-back issue).
  assign pop = ~fifo_empty & ((state_q == S_IDLE) | rsp_hs);

  assign head     = fifo_mem_q[rd_ptr_q];
  assign wr_entry = '{op: req_op_i, a: req_a_i, b: req_b_i, tag: req_tag_i};

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Issue / response FSM
  // ---------------------------------------------------------------------
  logic [3:0]      op_q;
  logic [31:0]     src_a_q;
  logic [31:0]     src_b_q;
  logic [3:0]      tag_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_result_q;
  logic            rsp_zero_q;
  logic            rsp_err_q;
  logic [3:0]      rsp_tag_q;
  logic [CNTW-1:0] done_cnt_q;
  logic            op_illegal;

  // Opcodes 1000..1011 are the only illegal codes.
  assign op_illegal = (op_q[3:2] == 2'b10);

  // The operand registers only change on the edge that enters ISSUE, so
  // driving the ALU straight from them holds the last values elsewhere.
  assign alu_src1_o = src_a_q;
  assign alu_src2_o = src_b_q;
  assign alu_ctrl_o = op_q;

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign done_cnt_o   = done_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tag_q    <= '0;
      done_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            op_q    <= head.op;
            src_a_q <= head.a;
            src_b_q <= head.b;
            tag_q   <= head.tag;
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          rsp_tag_q   <= tag_q;
          rsp_valid_q <= 1'b1;
          if (op_illegal) begin
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b1;
            rsp_err_q    <= 1'b1;
          end else begin
            rsp_result_q <= alu_result_i;
            rsp_zero_q   <= alu_zero_i;
            rsp_err_q    <= 1'b0;
          end
          state_q <= S_HOLD;
        end

        S_HOLD: begin
          if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
            done_cnt_q  <= done_cnt_q + CNTW'(1);
            if (pop) begin
              op_q    <= head.op;
              src_a_q <= head.a;
              src_b_q <= head.b;
              tag_q   <= head.tag;
              state_q <= S_ISSUE;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// ---------------------------------------------------------------------------
// tb_alu_dispatch
//
// Directed bench for alu_dispatch with a behavioural ALU attached. Every
// accepted request pushes its hand-computed expected response into a
// scoreboard queue; an independent monitor pops and compares on each
// response handshake. The DUT counter is built 4 bits wide so that the
// wrap case is reachable quickly.
// ---------------------------------------------------------------------------
module tb_alu_dispatch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic [3:0]  req_tag_i;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o;
  logic        rsp_err_o;
  logic [3:0]  rsp_tag_o;
  logic [3:0]  done_cnt_o;

  always #5 clk_i = ~clk_i;

  alu_dispatch #(.DEPTH(4), .CNTW(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_tag_i    (req_tag_i),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_result_i (alu_result_i),
    .alu_zero_i   (alu_zero_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_zero_o   (rsp_zero_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_tag_o    (rsp_tag_o),
    .done_cnt_o   (done_cnt_o)
  );

  // Behavioural ALU. Illegal codes return garbage so that any leak of the
  // ALU result into an error response is visible.
  logic [31:0] alu_r;
  logic        alu_legal;
  always_comb begin
    alu_r     = 32'hDEADBEEF;
    alu_legal = 1'b1;
    case (alu_ctrl_o)
      4'b0000: alu_r = alu_src1_o & alu_src2_o;
      4'b0001: alu_r = alu_src1_o | alu_src2_o;
      4'b0010: alu_r = alu_src1_o + alu_src2_o;
      4'b0011: alu_r = alu_src1_o ^ alu_src2_o;
      4'b0100: alu_r = alu_src1_o << alu_src2_o[4:0];
      4'b0101: alu_r = alu_src1_o >> alu_src2_o[4:0];
      4'b0110: alu_r = alu_src1_o - alu_src2_o;
      4'b0111: alu_r = {31'd0, $signed(alu_src1_o) < $signed(alu_src2_o)};
      4'b1100: alu_r = ~(alu_src1_o | alu_src2_o);
      4'b1101: alu_r = 32'($signed(alu_src1_o) >>> alu_src2_o[4:0]);
      4'b1110: alu_r = alu_src1_o - alu_src2_o;
      4'b1111: alu_r = alu_src2_o;
      default: alu_legal = 1'b0;
    endcase
    alu_result_i = alu_r;
    alu_zero_i   = alu_legal ? (alu_r == 32'd0) : 1'b0;
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        z;
    logic        e;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        e;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs = -1;
  bit   gap_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] tag,
                              input logic [31:0] res, input logic z,
                              input logic e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.res = res; v.z = z; v.e = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake occurs on the next rising edge when valid and
  // ready are both high at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && rsp_valid_o && rsp_ready_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got tag %0d result 0x%08h, expected no response",
                   rsp_tag_o, rsp_result_o);
        end else begin
          e = sb_q.pop_front();
          $display("rsp tag=%0d result=0x%08h zero=%0b err=%0b", rsp_tag_o,
                   rsp_result_o, rsp_zero_o, rsp_err_o);
          check("rsp_result", rsp_result_o, e.res);
          check("rsp_zero", 32'(rsp_zero_o), 32'(e.z));
          check("rsp_err", 32'(rsp_err_o), 32'(e.e));
          check("rsp_tag", 32'(rsp_tag_o), 32'(e.tag));
          if (gap_en && last_hs >= 0) check("rsp_gap", 32'(cyc - last_hs), 32'd2);
          last_hs = cyc;
        end
      end
    end
  end

  // Present a request for one cycle; called and returns at posedge+1.
  task automatic drive_req(input vec_t v, output bit acc);
    req_valid_i = 1'b1;
    req_op_i    = v.op;
    req_a_i     = v.a;
    req_b_i     = v.b;
    req_tag_i   = v.tag;
    @(negedge clk_i);
    acc = req_ready_o;
    if (acc) sb_q.push_back('{res: v.res, z: v.z, e: v.e, tag: v.tag});
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    $display("req op=%04b a=0x%08h b=0x%08h tag=%0d accepted=%0b", v.op, v.a, v.b, v.tag, acc);
  endtask

  task automatic push_wait(input vec_t v);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) drive_req(v, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got not accepted, expected accept within 50 cycles");
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() == 0 && !rsp_valid_o) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  vec_t fill_v [6];
  vec_t strm_v [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n_acc;

    fill_v[0] = mk(4'b0000, 32'hF0F000FF, 32'h0FF00F0F, 4'd0, 32'h00F0000F, 1'b0, 1'b0);
    fill_v[1] = mk(4'b0001, 32'h00001200, 32'h00000034, 4'd1, 32'h00001234, 1'b0, 1'b0);
    fill_v[2] = mk(4'b0110, 32'd3,        32'd5,        4'd2, 32'hFFFFFFFE, 1'b0, 1'b0);
    fill_v[3] = mk(4'b0111, 32'hFFFFFFFF, 32'd1,        4'd3, 32'd1,        1'b0, 1'b0);
    fill_v[4] = mk(4'b1100, 32'hFFFF0000, 32'h0000FFFF, 4'd4, 32'd0,        1'b1, 1'b0);
    fill_v[5] = mk(4'b0011, 32'h0000000F, 32'h000000F0, 4'd5, 32'h000000FF, 1'b0, 1'b0);

    strm_v[0] = mk(4'b0100, 32'd1,        32'd4,        4'd8,  32'd16,        1'b0, 1'b0);
    strm_v[1] = mk(4'b0101, 32'h80000000, 32'd31,       4'd9,  32'd1,         1'b0, 1'b0);
    strm_v[2] = mk(4'b1101, 32'h80000000, 32'd4,        4'd10, 32'hF8000000,  1'b0, 1'b0);
    strm_v[3] = mk(4'b1111, 32'd0,        32'hCAFEBABE, 4'd11, 32'hCAFEBABE,  1'b0, 1'b0);
    strm_v[4] = mk(4'b0010, 32'hFFFFFFFF, 32'd1,        4'd12, 32'd0,         1'b1, 1'b0);
    strm_v[5] = mk(4'b0011, 32'hAAAA5555, 32'h5555AAAA, 4'd13, 32'hFFFFFFFF,  1'b0, 1'b0);
    strm_v[6] = mk(4'b1011, 32'd1,        32'd1,        4'd14, 32'd0,         1'b1, 1'b1);
    strm_v[7] = mk(4'b1000, 32'd7,        32'd0,        4'd15, 32'd0,         1'b1, 1'b1);

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    req_tag_i   = '0;
    rsp_ready_i = 1'b0;

    // Reset values
    tick(2);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_done_cnt", 32'(done_cnt_o), 32'd0);
    check("rst_alu_src1", alu_src1_o, 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
    check("rst_rsp_result", rsp_result_o, 32'd0);
    rst_i = 1'b0;
    tick(1);

    // Single add with latency probe; consumer initially stalled
    drive_req(mk(4'b0010, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b0), acc);
    check("add_accept", 32'(acc), 32'd1);
    check("lat_e0_valid", 32'(rsp_valid_o), 32'd0);
    tick(1);
    check("lat_e1_valid", 32'(rsp_valid_o), 32'd0);
    check("issue_src1", alu_src1_o, 32'd5);
    check("issue_src2", alu_src2_o, 32'd7);
    check("issue_ctrl", 32'(alu_ctrl_o), 32'd2);
    tick(1);
    check("lat_e2_valid", 32'(rsp_valid_o), 32'd1);
    tick(2);
    check("hold_valid", 32'(rsp_valid_o), 32'd1);
    check("hold_result", rsp_result_o, 32'd12);
    check("hold_src1", alu_src1_o, 32'd5);
    rsp_ready_i = 1'b1;
    wait_drain();
    check("done_after_add", 32'(done_cnt_o), 32'd1);

    // bne with equal operands, then illegal opcode 1001
    push_wait(mk(4'b1110, 32'd9, 32'd9, 4'd5, 32'd0, 1'b1, 1'b0));
    push_wait(mk(4'b1001, 32'd1, 32'd2, 4'd6, 32'd0, 1'b1, 1'b1));
    wait_drain();
    check("done_after_bne", 32'(done_cnt_o), 32'd3);

    // Fill with consumer stalled: DEPTH in FIFO plus one held
    rsp_ready_i = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive_req(fill_v[i], acc);
      if (acc) n_acc++;
    end
    check("fill_accepted", 32'(n_acc), 32'd5);
    check("fill_req_ready", 32'(req_ready_o), 32'd0);
    rsp_ready_i = 1'b1;
    wait_drain();
    check("done_after_fill", 32'(done_cnt_o), 32'd8);
    check("ready_after_fill", 32'(req_ready_o), 32'd1);

    // Reset while holding a response with 3 requests queued
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_wait(fill_v[i]);
    check("pre_rst_valid", 32'(rsp_valid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
    check("mid_rst_ready", 32'(req_ready_o), 32'd1);
    check("mid_rst_done", 32'(done_cnt_o), 32'd0);
    sb_q.delete();
    tick(1);
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick(12);
    check("post_rst_valid", 32'(rsp_valid_o), 32'd0);
    check("post_rst_done", 32'(done_cnt_o), 32'd0);

    // Streaming with consumer always ready: one response every 2 cycles
    last_hs = -1;
    gap_en  = 1'b1;
    for (int i = 0; i < 8; i++) push_wait(strm_v[i]);
    wait_drain();
    gap_en = 1'b0;
    check("done_after_stream", 32'(done_cnt_o), 32'd8);

    // Nine more completions: 17 in total wraps the 4-bit counter to 1
    for (int i = 0; i < 9; i++) begin
      push_wait(mk(4'b0010, 32'(i), 32'd100, 4'(i), 32'(i + 100), 1'b0, 1'b0));
    end
    wait_drain();
    check("done_wrap", 32'(done_cnt_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the request FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter CNTW, default 16, SHALL set the width of the completed-operation counter.
REQ-003 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 req_valid_i  input  1  SHALL mark a valid request.
REQ-006 req_ready_o  output  1  SHALL indicate FIFO space.
REQ-007 req_op_i  input  4  SHALL carry the ALU operation code.
REQ-008 req_a_i, req_b_i  input  32 each  SHALL carry the operands.
REQ-009 req_tag_i  input  4  SHALL carry the requester tag.
REQ-010 alu_src1_o, alu_src2_o  output  32 each  SHALL drive the ALU operands.
REQ-011 alu_ctrl_o  output  4  SHALL drive the ALU control code.
REQ-012 alu_result_i  input  32  SHALL carry the combinational ALU result.
REQ-013 alu_zero_i  input  1  SHALL carry the ALU zero flag.
REQ-014 rsp_valid_o  output  1  SHALL mark a valid response.
REQ-015 rsp_ready_i  input  1  SHALL indicate that the consumer accepts the response.
REQ-016 rsp_result_o  output  32  SHALL carry the captured result.
REQ-017 rsp_zero_o  output  1  SHALL carry the captured zero flag.
REQ-018 rsp_err_o  output  1  SHALL flag an illegal opcode.
REQ-019 rsp_tag_o  output  4  SHALL echo the request tag.
REQ-020 done_cnt_o  output  CNTW  SHALL count completed response handshakes.

Function
REQ-021 A request SHALL be accepted (pushed to the FIFO) on any edge where req_valid_i and req_ready_o are both 1; req_ready_o SHALL equal not-full.
REQ-022 Legal opcodes SHALL be 0000, 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1100, 1101, 1110 and 1111; opcodes 1000-1011 SHALL be illegal.
REQ-023 The FSM SHALL have the states IDLE, ISSUE and HOLD.
REQ-024 IDLE SHALL, when the FIFO is non-empty, pop the head into the operand/op/tag registers and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-025 ISSUE SHALL last exactly one cycle; alu_src1_o, alu_src2_o and alu_ctrl_o SHALL be driven from the operand registers, and at the closing edge the block SHALL capture alu_result_i, alu_zero_i and the tag into the response registers, set rsp_valid_o, and move to HOLD.
REQ-026 For an illegal opcode, ISSUE SHALL capture result 0x00000000, zero 1 and err 1, ignoring the ALU inputs; for a legal opcode, err SHALL be 0.
REQ-027 HOLD SHALL keep every rsp_* output stable until an edge with rsp_ready_i=1; on that edge rsp_valid_o SHALL clear and done_cnt_o SHALL increment, wrapping from all-ones to 0.
REQ-028 On the HOLD handshake edge, the block SHALL pop the FIFO and go directly to ISSUE if the FIFO is non-empty; otherwise it SHALL go to IDLE.
REQ-029 Latency SHALL be as follows: for a request accepted at edge E0 into an empty FIFO with the FSM in IDLE, rsp_valid_o SHALL rise after edge E0+2.
REQ-030 Back-to-back throughput with rsp_ready_i held at 1 SHALL be one response per 2 cycles.
REQ-031 Simultaneous push and pop SHALL be permitted; the FIFO occupancy SHALL then be unchanged.
REQ-032 When the FIFO is full, req_ready_o SHALL be 0 and no push SHALL occur, even if a pop happens on the same edge.
REQ-033 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-034 Responses SHALL be returned in request order.
REQ-035 Outside ISSUE, alu_src1_o, alu_src2_o and alu_ctrl_o SHALL hold their last values.

Reset
REQ-036 While rst_i=1, the FSM SHALL be in IDLE and the FIFO SHALL be empty.
REQ-037 While rst_i=1, all alu_*, rsp_* and done_cnt_o outputs SHALL be 0, and req_ready_o SHALL be 1.
REQ-038 Reset asserted mid-operation SHALL discard all queued and in-flight requests immediately, with no partial response.

Verification
REQ-039 Single add: push op 0010, a=5, b=7, tag=3 -> after 2 edges, rsp_valid_o=1, result 12, zero 0, err 0, tag 3.
REQ-040 bne: push op 1110, a=b=9 -> result 0, zero = alu_zero_i as driven by the bench (1 for the inverted-flag model); also check the illegal opcode 1001 -> result 0, zero 1, err 1, and no dependence on alu_result_i.
REQ-041 Fill and backpressure: hold rsp_ready_i=0 and push 6 requests -> exactly DEPTH+1 are accepted (4 in the FIFO plus 1 in HOLD), and req_ready_o=0 afterwards; release -> tags come out in order.
REQ-042 Streaming: 8 requests with rsp_ready_i=1 -> responses arrive every 2 cycles, and done_cnt_o=8.
REQ-043 Reset during HOLD with 3 entries queued -> rsp_valid_o=0 and req_ready_o=1 immediately; no stale response appears after reset releases.
REQ-044 Counter wrap: with CNTW=4, 17 completions -> done_cnt_o=1.
